// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, port select, latency bounds.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_D
  } port_t;

  localparam int unsigned LATENCY_MIN = 0;
  localparam int unsigned LATENCY_MAX = 7;

  // A word address is in range when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> aw) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read.
module mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk1) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder arbitrating a loader, a data port and a fetch port onto one array.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_gnt,
  output logic              err,
  output logic              busy
);

  localparam logic [2:0] LAT_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  port_t       port_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        rng_ok;
  logic        resp;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // State register, wait counter and request capture
  always_ff @(posedge clk1) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      port_q  <= PORT_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_WAIT && state_nxt == ST_WAIT) ? cnt + 3'd1 : '0;
      if (d_gnt) begin
        port_q  <= PORT_D;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
      end else if (if_gnt) begin
        port_q  <= PORT_IF;
        addr_q  <= if_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (d_gnt || if_gnt) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == LAT_LAST) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rng_ok = addr_in_range(addr_q, ADDR_W);

  // Outputs are forced low while rst is held, even before the state register has settled.
  always_comb begin
    ld_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    resp      = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      if (state == ST_IDLE) begin
        if (ld_en)       ld_gnt = 1'b1;
        else if (d_req)  d_gnt  = 1'b1;
        else if (if_req) if_gnt = 1'b1;
      end
      resp = (state == ST_RESP);
      busy = (state != ST_IDLE);
    end
    if_rvalid = resp && (port_q == PORT_IF);
    d_rvalid  = resp && (port_q == PORT_D);
    err       = resp && !rng_ok;
    if_rdata  = (if_rvalid && rng_ok) ? mem_rdata : '0;
    d_rdata   = (d_rvalid && rng_ok && !we_q) ? mem_rdata : '0;
  end

  // Loader and RESP-cycle accesses never coincide since loader grants only happen in IDLE.
  always_comb begin
    mem_we    = ld_gnt || (resp && we_q && rng_ok);
    mem_addr  = ld_gnt ? ld_addr : addr_q[ADDR_W-1:0];
    mem_wdata = ld_gnt ? ld_data : wdata_q;
  end

  mem_array #(.ADDR_W(ADDR_W)) u_mem_array (
    .clk1  (clk1),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2 and LATENCY=0.
module tb_mem_responder;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_gnt, err, busy;

  logic        z_if_req = 1'b0;
  logic [31:0] z_if_addr = '0;
  logic        z_if_gnt, z_if_rvalid;
  logic [31:0] z_if_rdata;
  logic        z_d_gnt, z_d_rvalid;
  logic [31:0] z_d_rdata;
  logic        z_ld_en = 1'b0;
  logic [9:0]  z_ld_addr = '0;
  logic [31:0] z_ld_data = '0;
  logic        z_ld_gnt, z_err, z_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .err(err), .busy(busy)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
    .clk1(clk1), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_gnt(z_if_gnt), .if_rvalid(z_if_rvalid), .if_rdata(z_if_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_gnt(z_d_gnt), .d_rvalid(z_d_rvalid), .d_rdata(z_d_rdata),
    .ld_en(z_ld_en), .ld_addr(z_ld_addr), .ld_data(z_ld_data), .ld_gnt(z_ld_gnt),
    .err(z_err), .busy(z_busy)
  );

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic test_reset();
    ld_en = 1'b1; d_req = 1'b1; if_req = 1'b1; z_if_req = 1'b1;
    repeat (2) step();
    #1;
    total++;
    if ({ld_gnt, d_gnt, if_gnt, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_gnt_busy got=%b exp=0000", {ld_gnt, d_gnt, if_gnt, busy});
    end
    total++;
    if ({if_rvalid, d_rvalid, err, z_if_gnt, z_busy} !== 5'b0 || if_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      bad++; $display("FAIL reset_resp got=%b if_rdata=%h d_rdata=%h exp=0", {if_rvalid, d_rvalid, err, z_if_gnt, z_busy}, if_rdata, d_rdata);
    end
    ld_en = 1'b0; d_req = 1'b0; if_req = 1'b0; z_if_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_loader_fetch();
    step(); ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'h0000_0AAA; #1;
    total++;
    if (ld_gnt !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ld_gnt got=%b busy=%b exp=1 0", ld_gnt, busy);
    end
    step(); ld_en = 1'b0; if_req = 1'b1; if_addr = 32'd5; #1;
    total++;
    if (if_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      bad++; $display("FAIL fetch_gnt got=%b exp=1", if_gnt);
    end
    for (int c = 1; c <= 4; c++) begin
      step(); if_req = 1'b0; #1;
      total++;
      if (if_rvalid !== (c == 3) || busy !== (c <= 3) || d_rvalid !== 1'b0) begin
        bad++; $display("FAIL fetch_timing c=%0d rvalid=%b busy=%b exp=%b %b", c, if_rvalid, busy, c == 3, c <= 3);
      end
      if (c == 3) begin
        total++;
        if (if_rdata !== 32'h0000_0AAA || err !== 1'b0) begin
          bad++; $display("FAIL fetch_data got=%h err=%b exp=00000aaa 0", if_rdata, err);
        end
      end
    end
  endtask

  task automatic test_store_load();
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'hDEAD_BEEF; #1;
    total++;
    if (d_gnt !== 1'b1) begin bad++; $display("FAIL store_gnt got=%b exp=1", d_gnt); end
    for (int c = 1; c <= 3; c++) begin
      step(); d_req = 1'b0; d_we = 1'b0; #1;
      total++;
      if (d_rvalid !== (c == 3) || (c == 3 && d_rdata !== 32'd0)) begin
        bad++; $display("FAIL store_ack c=%0d rvalid=%b rdata=%h exp=%b 0", c, d_rvalid, d_rdata, c == 3);
      end
    end
    step(); d_req = 1'b1; d_addr = 32'd10; #1;
    total++;
    if (d_gnt !== 1'b1) begin bad++; $display("FAIL load_gnt got=%b exp=1", d_gnt); end
    for (int c = 1; c <= 3; c++) begin
      step(); d_req = 1'b0; #1;
      total++;
      if (d_rvalid !== (c == 3) || (c == 3 && d_rdata !== 32'hDEAD_BEEF)) begin
        bad++; $display("FAIL load_data c=%0d rvalid=%b rdata=%h exp=%b deadbeef", c, d_rvalid, d_rdata, c == 3);
      end
    end
  endtask

  task automatic test_arbitration();
    step(); d_req = 1'b1; d_addr = 32'd10; if_req = 1'b1; if_addr = 32'd5; #1;
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL arb_first d_gnt=%b if_gnt=%b exp=1 0", d_gnt, if_gnt);
    end
    for (int c = 1; c <= 4; c++) begin
      step(); d_req = 1'b0; #1;
      total++;
      if (if_gnt !== (c == 4) || d_rvalid !== (c == 3) || if_rvalid !== 1'b0) begin
        bad++; $display("FAIL arb_wait c=%0d if_gnt=%b d_rvalid=%b exp=%b %b", c, if_gnt, d_rvalid, c == 4, c == 3);
      end
      if (c == 3) begin
        total++;
        if (d_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL arb_dload got=%h exp=deadbeef", d_rdata); end
      end
    end
    for (int c = 1; c <= 3; c++) begin
      step(); if_req = 1'b0; #1;
      total++;
      if (if_rvalid !== (c == 3) || (c == 3 && if_rdata !== 32'h0000_0AAA)) begin
        bad++; $display("FAIL arb_fetch c=%0d rvalid=%b rdata=%h exp=%b 00000aaa", c, if_rvalid, if_rdata, c == 3);
      end
    end
  endtask

  task automatic test_priority();
    step(); ld_en = 1'b1; ld_addr = 10'd7; ld_data = 32'h0000_0077; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7; #1;
    total++;
    if (ld_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      bad++; $display("FAIL prio_ld ld_gnt=%b d_gnt=%b exp=1 0", ld_gnt, d_gnt);
    end
    step(); ld_en = 1'b0; #1;
    total++;
    if (d_gnt !== 1'b1) begin bad++; $display("FAIL prio_pending got=%b exp=1", d_gnt); end
    repeat (3) begin step(); d_req = 1'b0; end
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000_0077) begin
      bad++; $display("FAIL prio_load rvalid=%b rdata=%h exp=1 00000077", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_out_of_range();
    step(); ld_en = 1'b1; ld_addr = 10'd0; ld_data = 32'h0000_CAFE;
    step(); ld_en = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    repeat (3) begin step(); d_req = 1'b0; end
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'd0 || err !== 1'b1) begin
      bad++; $display("FAIL oor_load rvalid=%b rdata=%h err=%b exp=1 0 1", d_rvalid, d_rdata, err);
    end
    step(); #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b exp=0", err); end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0400; d_wdata = 32'h1234_5678;
    repeat (3) begin step(); d_req = 1'b0; d_we = 1'b0; end
    #1;
    total++;
    if (d_rvalid !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL oor_store rvalid=%b err=%b exp=1 1", d_rvalid, err);
    end
    step(); d_req = 1'b1; d_addr = 32'd0;
    repeat (3) begin step(); d_req = 1'b0; end
    #1;
    total++;
    if (d_rdata !== 32'h0000_CAFE || err !== 1'b0) begin
      bad++; $display("FAIL oor_nowrite got=%h err=%b exp=0000cafe 0", d_rdata, err);
    end
  endtask

  task automatic test_reset_abort();
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'd10; d_wdata = 32'h1111_1111;
    step(); d_req = 1'b0; d_we = 1'b0; rst = 1'b1; #1;
    total++;
    if (busy !== 1'b0 || d_rvalid !== 1'b0) begin
      bad++; $display("FAIL abort_in_rst busy=%b rvalid=%b exp=0 0", busy, d_rvalid);
    end
    for (int c = 1; c <= 4; c++) begin
      step(); rst = 1'b0; #1;
      total++;
      if (d_rvalid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_quiet c=%0d rvalid=%b busy=%b exp=0 0", c, d_rvalid, busy);
      end
    end
    d_req = 1'b1; d_addr = 32'd10;
    repeat (3) begin step(); d_req = 1'b0; end
    #1;
    total++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL abort_nowrite rvalid=%b rdata=%h exp=1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_latency0();
    step(); z_ld_en = 1'b1; z_ld_addr = 10'd3; z_ld_data = 32'h0000_0033;
    step(); z_ld_en = 1'b0; z_if_req = 1'b1; z_if_addr = 32'd3; #1;
    total++;
    if (z_if_gnt !== 1'b1) begin bad++; $display("FAIL lat0_gnt got=%b exp=1", z_if_gnt); end
    step(); z_if_req = 1'b0; z_ld_en = 1'b1; z_ld_addr = 10'd4; z_ld_data = 32'h0000_0044; #1;
    total++;
    if (z_if_rvalid !== 1'b1 || z_if_rdata !== 32'h0000_0033 || z_busy !== 1'b1 || z_ld_gnt !== 1'b0) begin
      bad++; $display("FAIL lat0_resp rvalid=%b rdata=%h busy=%b ld_gnt=%b exp=1 00000033 1 0", z_if_rvalid, z_if_rdata, z_busy, z_ld_gnt);
    end
    step(); #1;
    total++;
    if (z_ld_gnt !== 1'b1 || z_busy !== 1'b0 || z_if_rvalid !== 1'b0) begin
      bad++; $display("FAIL lat0_idle ld_gnt=%b busy=%b rvalid=%b exp=1 0 0", z_ld_gnt, z_busy, z_if_rvalid);
    end
    step(); z_ld_en = 1'b0; z_if_req = 1'b1; z_if_addr = 32'd4;
    step(); z_if_req = 1'b0; #1;
    total++;
    if (z_if_rvalid !== 1'b1 || z_if_rdata !== 32'h0000_0044) begin
      bad++; $display("FAIL lat0_ldwrite rvalid=%b rdata=%h exp=1 00000044", z_if_rvalid, z_if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_loader_fetch();
    test_store_load();
    test_arbitration();
    test_priority();
    test_out_of_range();
    test_reset_abort();
    test_latency0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
